// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/DMA requesters, the arbiter and the data memory.
// The arbiter sits on the slave modport; the requesters and memory sit on master.
interface dmem_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int BURST_W = 2
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic               dma_req;
  logic               dma_we;
  logic [ADDR_W-1:0]  dma_addr;
  logic [BURST_W-1:0] dma_len;
  logic [DATA_W-1:0]  dma_wdata;
  logic               dma_ack;
  logic               dma_done;
  logic               dma_rvalid;
  logic [DATA_W-1:0]  dma_rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_ack, dma_done, dma_rvalid, dma_rdata,
    output mem_wr, mem_rd, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_ack, dma_done, dma_rvalid, dma_rdata,
    input  mem_wr, mem_rd, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU / DMA arbiter for the single-ported data memory: single-beat CPU
// accesses, fixed-length DMA bursts, starvation guard for the DMA side.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int BURST_W    = 2,
  parameter int STARVE_LIM = 4
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state;
  logic [BURST_W-1:0] r_beat;
  logic [BURST_W-1:0] r_len;
  logic [ADDR_W-1:0]  r_base;
  logic               r_we;
  logic [SW-1:0]      r_starve;
  logic               r_cpu_rv;
  logic               r_dma_rv;

  logic              w_idle;
  logic              w_burst;
  logic              w_starved;
  logic              w_cpu;
  logic              w_dma0;
  logic              w_dma;
  logic              w_we;
  logic              w_last;
  logic [ADDR_W-1:0] w_baddr;

  // Nothing is granted while reset is held, so memory never sees a beat.
  assign w_idle    = (r_state == S_IDLE) && !reset;
  assign w_burst   = (r_state == S_BURST) && !reset;
  assign w_starved = bus.dma_req && (r_starve == SW'(STARVE_LIM));
  assign w_cpu     = w_idle && bus.cpu_req && !w_starved;
  assign w_dma0    = w_idle && bus.dma_req && !w_cpu;
  assign w_dma     = w_dma0 || w_burst;
  assign w_we      = w_dma0 ? bus.dma_we : r_we;
  assign w_baddr   = r_base + ADDR_W'(r_beat);
  assign w_last    = w_dma0 ? (bus.dma_len == '0)
                            : (w_burst && (r_beat == r_len));

  assign bus.cpu_gnt    = w_cpu;
  assign bus.cpu_stall  = bus.cpu_req && !w_cpu;
  assign bus.cpu_rvalid = r_cpu_rv;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_ack    = w_dma;
  assign bus.dma_done   = w_last;
  assign bus.dma_rvalid = r_dma_rv;
  assign bus.dma_rdata  = bus.mem_rdata;

  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      w_cpu: begin
        bus.mem_wr    = bus.cpu_we;
        bus.mem_rd    = !bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      w_dma0: begin
        bus.mem_wr    = bus.dma_we;
        bus.mem_rd    = !bus.dma_we;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
      end
      w_burst: begin
        bus.mem_wr    = r_we;
        bus.mem_rd    = !r_we;
        bus.mem_addr  = w_baddr;
        bus.mem_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_len    <= '0;
      r_base   <= '0;
      r_we     <= 1'b0;
      r_starve <= '0;
      r_cpu_rv <= 1'b0;
      r_dma_rv <= 1'b0;
    end else begin
      r_cpu_rv <= w_cpu && !bus.cpu_we;
      r_dma_rv <= w_dma && !w_we;
      if (!bus.dma_req || w_dma0)
        r_starve <= '0;
      else if (w_cpu && (r_starve != SW'(STARVE_LIM)))
        r_starve <= r_starve + SW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_dma0) begin
            r_base <= bus.dma_addr;
            r_len  <= bus.dma_len;
            r_we   <= bus.dma_we;
            if (bus.dma_len != '0) begin
              r_state <= S_BURST;
              r_beat  <= BURST_W'(1);
            end
          end
        end
        S_BURST: begin
          if (r_beat == r_len) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + BURST_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model and a shadow memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic clr_mem;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(9), .BURST_W(2)) bus ();

  dmem_arbiter #(
    .DATA_W(32), .ADDR_W(9), .BURST_W(2), .STARVE_LIM(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] mem [512];
  logic [31:0] sm  [512];
  logic [31:0] r_rd;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
    end else begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) r_rd <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = r_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_len   = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    clr_mem = 1'b1;
    clr();
    bus.cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.cpu_gnt, bus.cpu_stall, bus.dma_ack, bus.dma_done} !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_ctrl: gnt/stall/ack/done=%b expected 0100",
               {bus.cpu_gnt, bus.cpu_stall, bus.dma_ack, bus.dma_done});
    end
    n_cmp++;
    if ({bus.mem_wr, bus.mem_rd, bus.cpu_rvalid, bus.dma_rvalid} !== 4'b0
        || bus.mem_addr !== 9'd0 || bus.mem_wdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mem: wr=%b rd=%b rv=%b%b addr=%0d wd=%h expected all 0",
               bus.mem_wr, bus.mem_rd, bus.cpu_rvalid, bus.dma_rvalid,
               bus.mem_addr, bus.mem_wdata);
    end
    clr_mem = 1'b0;
    tick();
    reset = 1'b0;
    clr();
  endtask

  task automatic test_cpu_rw();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 9'd5;
    bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.mem_wr !== 1'b1
        || bus.mem_addr !== 9'd5 || bus.mem_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL cpu_write: gnt=%b stall=%b wr=%b addr=%0d wd=%h expected 1 0 1 5 deadbeef",
               bus.cpu_gnt, bus.cpu_stall, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
    end
    sm[5] = 32'hDEADBEEF;
    tick();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_read: gnt=%b rd=%b wr=%b expected 1 1 0",
               bus.cpu_gnt, bus.mem_rd, bus.mem_wr);
    end
    tick();
    clr();
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b1 || bus.dma_rvalid !== 1'b0
        || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL cpu_rdata: rv=%b drv=%b data=%h expected 1 0 deadbeef",
               bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_dma_wrap();
    logic [8:0] ea;
    for (int i = 0; i < 4; i++) begin
      bus.dma_req   = (i == 0);
      bus.dma_we    = 1'b1;
      bus.dma_addr  = 9'd510;
      bus.dma_len   = 2'd3;
      bus.dma_wdata = 32'(i + 1);
      ea = 9'd510 + 9'(i);
      @(negedge clk);
      n_cmp++;
      if (bus.dma_ack !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== ea
          || bus.mem_wdata !== 32'(i + 1) || bus.dma_done !== (i == 3)) begin
        n_err++;
        $display("FAIL dma_wrap beat%0d: ack=%b wr=%b addr=%0d wd=%0d done=%b expected 1 1 %0d %0d %b",
                 i, bus.dma_ack, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                 bus.dma_done, ea, i + 1, (i == 3));
      end
      sm[ea] = 32'(i + 1);
      tick();
    end
    clr();
    @(negedge clk);
    n_cmp++;
    if (bus.dma_ack !== 1'b0 || bus.dma_done !== 1'b0) begin
      n_err++;
      $display("FAIL dma_wrap_end: ack=%b done=%b expected 0 0", bus.dma_ack, bus.dma_done);
    end
    n_cmp++;
    if (mem[510] !== 32'd1 || mem[511] !== 32'd2 || mem[0] !== 32'd3 || mem[1] !== 32'd4) begin
      n_err++;
      $display("FAIL dma_wrap_mem: %0d %0d %0d %0d expected 1 2 3 4",
               mem[510], mem[511], mem[0], mem[1]);
    end
    tick();
  endtask

  // Both requesters held: CPU wins 4 cycles, DMA read burst forced in, CPU stalls.
  task automatic test_starve_stall();
    logic e_cpu, e_dma, e_crv, e_drv;
    logic [8:0] ea;
    for (int k = 0; k < 10; k++) begin
      bus.cpu_req  = (k <= 8);
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 9'd5;
      bus.dma_req  = (k <= 8);
      bus.dma_we   = 1'b0;
      bus.dma_addr = 9'd510;
      bus.dma_len  = 2'd3;
      e_cpu = (k < 4) || (k == 8);
      e_dma = (k >= 4) && (k <= 7);
      e_crv = ((k >= 1) && (k <= 4)) || (k == 9);
      e_drv = (k >= 5) && (k <= 8);
      ea    = 9'd510 + 9'(k - 4);
      @(negedge clk);
      n_cmp++;
      if (bus.cpu_gnt !== e_cpu || bus.dma_ack !== e_dma
          || bus.cpu_stall !== (bus.cpu_req && !e_cpu)
          || bus.dma_done !== (k == 7)) begin
        n_err++;
        $display("FAIL starve_grant k=%0d: gnt=%b ack=%b stall=%b done=%b expected %b %b %b %b",
                 k, bus.cpu_gnt, bus.dma_ack, bus.cpu_stall, bus.dma_done,
                 e_cpu, e_dma, bus.cpu_req && !e_cpu, (k == 7));
      end
      if (e_dma) begin
        n_cmp++;
        if (bus.mem_addr !== ea || bus.mem_rd !== 1'b1) begin
          n_err++;
          $display("FAIL starve_addr k=%0d: addr=%0d rd=%b expected %0d 1",
                   k, bus.mem_addr, bus.mem_rd, ea);
        end
      end
      n_cmp++;
      if (bus.cpu_rvalid !== e_crv || bus.dma_rvalid !== e_drv) begin
        n_err++;
        $display("FAIL starve_rvalid k=%0d: crv=%b drv=%b expected %b %b",
                 k, bus.cpu_rvalid, bus.dma_rvalid, e_crv, e_drv);
      end
      if (e_drv) begin
        n_cmp++;
        if (bus.dma_rdata !== sm[9'd510 + 9'(k - 5)]) begin
          n_err++;
          $display("FAIL starve_rdata k=%0d: data=%h expected %h",
                   k, bus.dma_rdata, sm[9'd510 + 9'(k - 5)]);
        end
      end
      tick();
    end
    clr();
  endtask

  task automatic test_reset_mid_burst();
    for (int b = 0; b < 2; b++) begin
      bus.dma_req   = (b == 0);
      bus.dma_we    = 1'b1;
      bus.dma_addr  = 9'd100;
      bus.dma_len   = 2'd3;
      bus.dma_wdata = 32'hA0 + 32'(b);
      sm[9'd100 + 9'(b)] = 32'hA0 + 32'(b);
      tick();
    end
    bus.dma_wdata = 32'hA2;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.dma_ack, bus.dma_done, bus.mem_wr, bus.mem_rd} !== 4'b0
        || bus.mem_addr !== 9'd0 || bus.mem_wdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: ack=%b done=%b wr=%b rd=%b addr=%0d wd=%h expected all 0",
               bus.dma_ack, bus.dma_done, bus.mem_wr, bus.mem_rd,
               bus.mem_addr, bus.mem_wdata);
    end
    tick();
    reset = 1'b0;
    clr();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 9'd200;
    bus.cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_gnt !== 1'b1 || bus.dma_ack !== 1'b0 || bus.dma_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_cpu: gnt=%b ack=%b done=%b expected 1 0 0",
               bus.cpu_gnt, bus.dma_ack, bus.dma_done);
    end
    sm[200] = 32'h1234_5678;
    tick();
    clr();
    @(negedge clk);
    n_cmp++;
    if (bus.dma_ack !== 1'b0 || bus.dma_done !== 1'b0 || mem[102] !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_abandon: ack=%b done=%b mem102=%h expected 0 0 0",
               bus.dma_ack, bus.dma_done, mem[102]);
    end
    tick();
  endtask

  task automatic test_len0_back_to_back();
    logic [31:0] w;
    w = $urandom;
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 9'd300;
    bus.dma_len   = 2'd0;
    bus.dma_wdata = w;
    @(negedge clk);
    n_cmp++;
    if (bus.dma_ack !== 1'b1 || bus.dma_done !== 1'b1 || bus.mem_wr !== 1'b1
        || bus.mem_wdata !== w) begin
      n_err++;
      $display("FAIL len0_wr: ack=%b done=%b wr=%b wd=%h expected 1 1 1 %h",
               bus.dma_ack, bus.dma_done, bus.mem_wr, bus.mem_wdata, w);
    end
    sm[300] = w;
    tick();
    bus.dma_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.dma_ack !== 1'b1 || bus.dma_done !== 1'b1 || bus.mem_rd !== 1'b1
        || bus.mem_addr !== 9'd300) begin
      n_err++;
      $display("FAIL len0_b2b: ack=%b done=%b rd=%b addr=%0d expected 1 1 1 300",
               bus.dma_ack, bus.dma_done, bus.mem_rd, bus.mem_addr);
    end
    tick();
    clr();
    @(negedge clk);
    n_cmp++;
    if (bus.dma_ack !== 1'b0 || bus.dma_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0
        || bus.dma_rdata !== w) begin
      n_err++;
      $display("FAIL len0_rdata: ack=%b drv=%b crv=%b data=%h expected 0 1 0 %h",
               bus.dma_ack, bus.dma_rvalid, bus.cpu_rvalid, bus.dma_rdata, w);
    end
    tick();
  endtask

  task automatic test_random();
    logic [8:0]  q[$];
    logic        bwe = 1'b0;
    logic        hold = 1'b0;
    int          denied = 0;
    logic        pc = 1'b0, pd = 1'b0;
    logic [31:0] pcd = '0, pdd = '0;
    logic        e_cpu, e_dma, e_b0, e_done, e_wr, e_rd;
    logic [8:0]  e_addr;
    logic [31:0] e_wd;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) hold = ($urandom_range(0, 3) == 0);
      bus.cpu_req   = ($urandom_range(0, 3) != 0);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = 9'($urandom);
      bus.cpu_wdata = $urandom;
      bus.dma_req   = hold;
      bus.dma_we    = 1'($urandom);
      bus.dma_addr  = 9'($urandom);
      bus.dma_len   = 2'($urandom);
      bus.dma_wdata = $urandom;
      @(negedge clk);
      {e_cpu, e_dma, e_b0, e_done, e_wr, e_rd} = '0;
      e_addr = '0;
      e_wd   = '0;
      if (q.size() != 0) begin
        e_dma  = 1'b1;
        e_addr = q.pop_front();
        e_done = (q.size() == 0);
        e_wr   = bwe;
        e_rd   = !bwe;
        e_wd   = bus.dma_wdata;
      end else if (bus.cpu_req && !(bus.dma_req && denied == 4)) begin
        e_cpu  = 1'b1;
        e_addr = bus.cpu_addr;
        e_wr   = bus.cpu_we;
        e_rd   = !bus.cpu_we;
        e_wd   = bus.cpu_wdata;
      end else if (bus.dma_req) begin
        e_dma  = 1'b1;
        e_b0   = 1'b1;
        e_addr = bus.dma_addr;
        e_wr   = bus.dma_we;
        e_rd   = !bus.dma_we;
        e_wd   = bus.dma_wdata;
        e_done = (bus.dma_len == 2'd0);
        bwe    = bus.dma_we;
        for (int j = 1; j <= int'(bus.dma_len); j++)
          q.push_back(bus.dma_addr + 9'(j));
        hold = 1'b0;
      end
      if (!bus.dma_req || e_b0) denied = 0;
      else if (e_cpu && denied < 4) denied++;
      n_cmp++;
      if ({bus.cpu_gnt, bus.cpu_stall, bus.dma_ack, bus.dma_done, bus.mem_wr, bus.mem_rd}
          !== {e_cpu, bus.cpu_req && !e_cpu, e_dma, e_done, e_wr, e_rd}) begin
        n_err++;
        $display("FAIL rand_ctrl n=%0d: gnt/stall/ack/done/wr/rd=%b expected %b",
                 n, {bus.cpu_gnt, bus.cpu_stall, bus.dma_ack, bus.dma_done, bus.mem_wr, bus.mem_rd},
                 {e_cpu, bus.cpu_req && !e_cpu, e_dma, e_done, e_wr, e_rd});
      end
      n_cmp++;
      if (bus.mem_addr !== e_addr || bus.mem_wdata !== e_wd) begin
        n_err++;
        $display("FAIL rand_bus n=%0d: addr=%0d wd=%h expected %0d %h",
                 n, bus.mem_addr, bus.mem_wdata, e_addr, e_wd);
      end
      n_cmp++;
      if (bus.cpu_rvalid !== pc || bus.dma_rvalid !== pd) begin
        n_err++;
        $display("FAIL rand_rvalid n=%0d: crv=%b drv=%b expected %b %b",
                 n, bus.cpu_rvalid, bus.dma_rvalid, pc, pd);
      end
      if (pc || pd) begin
        n_cmp++;
        if ((pc && bus.cpu_rdata !== pcd) || (pd && bus.dma_rdata !== pdd)) begin
          n_err++;
          $display("FAIL rand_rdata n=%0d: cpu=%h dma=%h expected %h %h",
                   n, bus.cpu_rdata, bus.dma_rdata, pcd, pdd);
        end
      end
      pc  = e_cpu && e_rd;
      pd  = e_dma && e_rd;
      pcd = sm[e_addr];
      pdd = sm[e_addr];
      if (e_wr) sm[e_addr] = e_wd;
      tick();
    end
    clr();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) sm[i] = 32'h0;
    test_reset();
    test_cpu_rw();
    test_dma_wrap();
    test_starve_stall();
    test_reset_mid_burst();
    test_len0_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
